// File: rtl/dw_conv_post_process.sv
// -----------------------------------------------------------------------------
// dw_conv_post_process
//
// Tail of the depthwise-conv datapath. Each valid_in beat carries one 3x3
// accumulator per channel for one input pixel. Beats whose window is not fully
// inside the frame (row < 2 or col < 2) are discarded. Kept beats are
// requantized per channel in a non-stalling 3-stage pipeline:
//   S1: multiply by the unsigned requant multiplier
//   S2: rounding arithmetic right shift (round half toward +inf)
//   S3: saturate to DATA_WIDTH, optional ReLU clamp
// Results are queued in a small FIFO so the next layer can apply backpressure.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   acc_in / valid_in         packed signed accumulators, channel c at
//                             [c*ACC_WIDTH +: ACC_WIDTH]; no upstream stall
//   data_out / valid_out /    FIFO head (same channel packing), non-empty flag,
//   out_ready                 and downstream accept
//   img_width / img_height    frame geometry, sampled on frame_start
//   frame_start               restart position counters at (0,0)
//   quant_mult / quant_shift  requantization multiplier and right shift
//   relu_en                   clamp negative results to 0
//   frame_done                1-cycle pulse after the last beat of a frame
//   overflow                  sticky: a result was lost to a full FIFO
// -----------------------------------------------------------------------------
module dw_conv_post_process #(
  parameter int OUT_CHANNEL_NUM = 18,
  parameter int ACC_WIDTH       = 20,
  parameter int DATA_WIDTH      = 8,
  parameter int MULT_WIDTH      = 16,
  parameter int SHIFT_WIDTH     = 5,
  parameter int DIM_WIDTH       = 9,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [OUT_CHANNEL_NUM*ACC_WIDTH-1:0]  acc_in,
  input  logic                                  valid_in,
  output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out,
  output logic                                  valid_out,
  input  logic                                  out_ready,
  input  logic [DIM_WIDTH-1:0]                  img_width,
  input  logic [DIM_WIDTH-1:0]                  img_height,
  input  logic                                  frame_start,
  input  logic [MULT_WIDTH-1:0]                 quant_mult,
  input  logic [SHIFT_WIDTH-1:0]                quant_shift,
  input  logic                                  relu_en,
  output logic                                  frame_done,
  output logic                                  overflow
);

  localparam int PROD_W = ACC_WIDTH + MULT_WIDTH + 1;
  localparam int OUT_W  = OUT_CHANNEL_NUM * DATA_WIDTH;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

  // ---------------------------------------------------------------------------
  // Position tracking and keep decision
  // ---------------------------------------------------------------------------
  logic [DIM_WIDTH-1:0] col_q, col_d;
  logic [DIM_WIDTH-1:0] row_q, row_d;
  logic [DIM_WIDTH-1:0] width_q, width_d;
  logic [DIM_WIDTH-1:0] height_q, height_d;
  logic                 frame_done_q, frame_done_d;
  logic                 keep;

  // A frame_start beat is evaluated as position (0,0) against the new geometry.
  logic [DIM_WIDTH-1:0] eff_col, eff_row;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_col      = frame_start ? '0 : col_q;
    eff_row      = frame_start ? '0 : row_q;
    width_d      = frame_start ? img_width  : width_q;
    height_d     = frame_start ? img_height : height_q;
    col_d        = eff_col;
    row_d        = eff_row;
    keep         = 1'b0;
    frame_done_d = 1'b0;
    if (valid_in) begin
      keep = (eff_row >= DIM_WIDTH'(2)) && (eff_col >= DIM_WIDTH'(2));
      if (eff_col == width_d - DIM_WIDTH'(1)) begin
        col_d = '0;
        if (eff_row == height_d - DIM_WIDTH'(1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = eff_row + DIM_WIDTH'(1);
        end
      end else begin
        col_d = eff_col + DIM_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      width_q      <= DIM_WIDTH'(3);
      height_q     <= DIM_WIDTH'(3);
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      width_q      <= width_d;
      height_q     <= height_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

  // ---------------------------------------------------------------------------
  // Requantization pipeline (never stalls)
  // ---------------------------------------------------------------------------
  logic                     v1_q, v2_q, v3_q;
  logic signed [PROD_W-1:0] prod_d  [OUT_CHANNEL_NUM];
  logic signed [PROD_W-1:0] p1_q    [OUT_CHANNEL_NUM];
  logic signed [PROD_W-1:0] round_d [OUT_CHANNEL_NUM];
  logic signed [PROD_W-1:0] r2_q    [OUT_CHANNEL_NUM];
  logic signed [PROD_W-1:0] bias;
  logic signed [PROD_W-1:0] lo_bound;
  logic signed [MULT_WIDTH:0] mult_s;
  logic [OUT_W-1:0]         sat_d;
  logic [OUT_W-1:0]         s3_q;

  // Zero-extend the multiplier so it always acts as a positive scale.
  assign mult_s = $signed({1'b0, quant_mult});

  always_comb begin
    bias = '0;
    if (quant_shift != '0) begin
      bias = PROD_W'(1) << (quant_shift - SHIFT_WIDTH'(1));
    end
    lo_bound = relu_en ? '0 : SAT_MIN;
    sat_d    = '0;
    for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
      prod_d[c]  = PROD_W'($signed(acc_in[c*ACC_WIDTH +: ACC_WIDTH])) * PROD_W'(mult_s);
      round_d[c] = (p1_q[c] + bias) >>> quant_shift;
      if (r2_q[c] > SAT_MAX) begin
        sat_d[c*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
      end else if (r2_q[c] < lo_bound) begin
        sat_d[c*DATA_WIDTH +: DATA_WIDTH] = lo_bound[DATA_WIDTH-1:0];
      end else begin
        sat_d[c*DATA_WIDTH +: DATA_WIDTH] = r2_q[c][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= keep;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // NOTE: datapath and FIFO storage carry no reset; only the valid bits and
  // pointers need one, since data is never observed without its valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
      p1_q[c] <= prod_d[c];
      r2_q[c] <= round_d[c];
    end
    s3_q <= sat_d;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign pop   = !empty && out_ready;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push  = v3_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || (v3_q && full && !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= s3_q;
    end
  end

  assign data_out  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign valid_out = !empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dw_conv_post_process.sv
// -----------------------------------------------------------------------------
// tb_dw_conv_post_process
//
// Directed scoreboard bench. Stimulus pushes the hand-computed result of every
// kept beat into exp_q; an independent monitor pops and compares whenever the
// DUT hands over data (valid_out && out_ready). Even channels carry one value
// and odd channels another so per-channel independence is visible.
// -----------------------------------------------------------------------------
module tb_dw_conv_post_process;

  localparam int N  = 18;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MW = 16;
  localparam int SW = 5;
  localparam int DM = 9;

  typedef struct {
    int acc_a;
    int acc_b;
    int exp_a;
    int exp_b;
    bit push;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   acc_in;
  logic              valid_in;
  logic [N*DW-1:0]   data_out;
  logic              valid_out;
  logic              out_ready;
  logic [DM-1:0]     img_width;
  logic [DM-1:0]     img_height;
  logic              frame_start;
  logic [MW-1:0]     quant_mult;
  logic [SW-1:0]     quant_shift;
  logic              relu_en;
  logic              frame_done;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  vec_t vec_q[$];
  logic [N*DW-1:0] exp_q[$];

  dw_conv_post_process dut (
    .clk         (clk),
    .rst         (rst),
    .acc_in      (acc_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .img_width   (img_width),
    .img_height  (img_height),
    .frame_start (frame_start),
    .quant_mult  (quant_mult),
    .quant_shift (quant_shift),
    .relu_en     (relu_en),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] make_acc(input int a, input int b);
    logic [N*AW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = (c % 2 == 1) ? AW'(b) : AW'(a);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] make_exp(input int a, input int b);
    logic [N*DW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = (c % 2 == 1) ? DW'(b) : DW'(a);
    return v;
  endfunction

  task automatic add_vec(input int aa, input int ab, input int ea, input int eb,
                         input bit p = 1'b1);
    vec_t v;
    v.acc_a = aa; v.acc_b = ab; v.exp_a = ea; v.exp_b = eb; v.push = p;
    vec_q.push_back(v);
  endtask

  task automatic set_q(input int m, input int s, input bit r);
    quant_mult  = MW'(m);
    quant_shift = SW'(s);
    relu_en     = r;
  endtask

  // Sends n beats of a w-wide frame; kept positions take the next vector.
  task automatic send_frame(input int w, input int h, input int n, input bit fs);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in    = 1'b1;
      frame_start = fs && (i == 0);
      if (fs && i == 0) begin
        img_width  = DM'(w);
        img_height = DM'(h);
      end
      if ((i / w) >= 2 && (i % w) >= 2 && vec_q.size() > 0) begin
        v = vec_q.pop_front();
        acc_in = make_acc(v.acc_a, v.acc_b);
        if (v.push) exp_q.push_back(make_exp(v.exp_a, v.exp_b));
      end else begin
        acc_in = make_acc(i, i);
      end
    end
    @(posedge clk); #1;
    valid_in    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge clk);
    #1;
    check("fifo_empty_after_drain", valid_out, 1'b0);
  endtask

  // Monitor: independent of stimulus, compares every handed-over result.
  always @(negedge clk) begin
    if (!rst && valid_out && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h, required no output", data_out);
      end else begin
        check("output", data_out, exp_q.pop_front());
      end
    end
    if (!rst && frame_done) fd_count++;
  end

  initial begin
    rst = 1'b1; acc_in = '0; valid_in = 1'b0; out_ready = 1'b1;
    img_width = DM'(5); img_height = DM'(4); frame_start = 1'b0;
    set_q(1, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_valid_out", valid_out, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst = 1'b0;

    // 1: keep rule on a 5x4 frame, acc = beat index
    add_vec(12, 12, 12, 12); add_vec(13, 13, 13, 13); add_vec(14, 14, 14, 14);
    add_vec(17, 17, 17, 17); add_vec(18, 18, 18, 18); add_vec(19, 19, 19, 19);
    send_frame(5, 4, 20, 1'b1);
    check("frame_done_pulse", frame_done, 1'b1);
    @(posedge clk); #1;
    check("frame_done_single_cycle", frame_done, 1'b0);
    wait_drain();

    // 2: rounding (4x3 frames keep beats 10 and 11)
    set_q(1, 1, 1'b0);
    add_vec(5, -3, 3, -1); add_vec(-4, 7, -2, 4);
    send_frame(4, 3, 12, 1'b1);
    wait_drain();
    set_q(3, 2, 1'b0);
    add_vec(7, -7, 5, -5); add_vec(0, 1, 0, 1);
    send_frame(4, 3, 12, 1'b1);
    wait_drain();
    set_q(65535, 16, 1'b0);
    add_vec(-1, 2, -1, 2); add_vec(100, -100, 100, -100);
    send_frame(4, 3, 12, 1'b1);
    wait_drain();

    // 3: saturation and ReLU
    set_q(1, 0, 1'b0);
    add_vec(1000, -1000, 127, -128); add_vec(128, -129, 127, -128);
    send_frame(4, 3, 12, 1'b1);
    wait_drain();
    set_q(1, 0, 1'b1);
    add_vec(-5, 1000, 0, 127); add_vec(-1000, 3, 0, 3);
    send_frame(4, 3, 12, 1'b1);
    wait_drain();

    // 4: FIFO full and overflow
    set_q(1, 0, 1'b0);
    check("overflow_clear_before_fill", overflow, 1'b0);
    out_ready = 1'b0;
    add_vec(1, -1, 1, -1); add_vec(2, -2, 2, -2); add_vec(3, -3, 3, -3);
    add_vec(4, -4, 4, -4); add_vec(5, -5, 5, -5, 1'b0); add_vec(6, -6, 6, -6, 1'b0);
    send_frame(5, 4, 20, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("overflow_set", overflow, 1'b1);
    check("valid_while_stalled", valid_out, 1'b1);
    check("head_while_stalled", data_out, make_exp(1, -1));
    out_ready = 1'b1;
    wait_drain();
    check("overflow_sticky", overflow, 1'b1);

    // 5: asynchronous reset mid-row 3 with two results queued
    out_ready = 1'b0;
    add_vec(50, 51, 50, 51, 1'b0); add_vec(52, 53, 52, 53, 1'b0);
    send_frame(4, 4, 14, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("fifo_holds_before_rst", valid_out, 1'b1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid_out", valid_out, 1'b0);
    check("async_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    // No frame_start: counters restart at (0,0) with 3x3 reset geometry.
    add_vec(42, -42, 42, -42);
    send_frame(3, 3, 9, 1'b0);
    check("frame_done_after_reset_geometry", frame_done, 1'b1);
    wait_drain();

    // 6: frame_start mid-frame with results still in flight
    add_vec(12, -12, 12, -12); add_vec(13, -13, 13, -13);
    send_frame(5, 4, 14, 1'b1);
    add_vec(20, -20, 20, -20); add_vec(21, -21, 21, -21); add_vec(22, -22, 22, -22);
    add_vec(23, -23, 23, -23); add_vec(24, -24, 24, -24); add_vec(25, -25, 25, -25);
    send_frame(5, 4, 20, 1'b1);
    wait_drain();

    check("frame_done_count", fd_count, 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
